mem_bus_dma: RTL and testbench

MEM_BUS_DMA -- requirements
Module: mem_bus_dma

---
 rtl/mem_bus_dma.sv | 131 +++++++++++++
 tb/tb_mem_bus_dma.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_dma.sv
// Single-channel word DMA: copies word_count 32-bit words from src_addr to dst_addr
// over a strobe-based memory bus, one read then one write per word.
module mem_bus_dma #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [LEN_WIDTH-1:0]  word_count,
  output logic                  busy,
  output logic                  done,
  output logic [LEN_WIDTH-1:0]  remaining,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_wmask,
  output logic                  mem_rstrb,
  output logic                  mem_access,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_rbusy,
  input  logic                  mem_wbusy
);

  typedef enum logic [2:0] {
    StIdle,
    StReadReq,
    StReadWait,
    StWrite,
    StDone
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] src_ptr_q, src_ptr_d;
  logic [ADDR_WIDTH-1:0] dst_ptr_q, dst_ptr_d;
  logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
  logic [31:0]           data_q, data_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      src_ptr_q   <= '0;
      dst_ptr_q   <= '0;
      remaining_q <= '0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      src_ptr_q   <= src_ptr_d;
      dst_ptr_q   <= dst_ptr_d;
      remaining_q <= remaining_d;
      data_q      <= data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    src_ptr_d   = src_ptr_q;
    dst_ptr_d   = dst_ptr_q;
    remaining_d = remaining_q;
    data_d      = data_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (word_count != '0) begin
            // Pointers are word aligned; the low two address bits are dropped.
            src_ptr_d   = {src_addr[ADDR_WIDTH-1:2], 2'b00};
            dst_ptr_d   = {dst_addr[ADDR_WIDTH-1:2], 2'b00};
            remaining_d = word_count;
            state_d     = StReadReq;
          end else begin
            state_d = StDone;
          end
        end
      end
      StReadReq: state_d = StReadWait;
      StReadWait: begin
        if (!mem_rbusy) begin
          data_d  = mem_rdata;
          state_d = StWrite;
        end
      end
      StWrite: begin
        if (!mem_wbusy) begin
          src_ptr_d   = src_ptr_q + ADDR_WIDTH'(4);
          dst_ptr_d   = dst_ptr_q + ADDR_WIDTH'(4);
          remaining_d = remaining_q - LEN_WIDTH'(1);
          state_d     = (remaining_q == LEN_WIDTH'(1)) ? StDone : StReadReq;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs decode purely from state and flops, so reset clears them without a clock.
  always_comb begin
    busy       = 1'b0;
    done       = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_wmask  = 4'b0000;
    mem_rstrb  = 1'b0;
    mem_access = 1'b0;
    unique case (state_q)
      StReadReq: begin
        busy       = 1'b1;
        mem_rstrb  = 1'b1;
        mem_access = 1'b1;
        mem_addr   = src_ptr_q;
      end
      StReadWait: begin
        busy       = 1'b1;
        mem_access = 1'b1;
        mem_addr   = src_ptr_q;
      end
      StWrite: begin
        busy       = 1'b1;
        mem_access = 1'b1;
        mem_addr   = dst_ptr_q;
        mem_wdata  = data_q;
        mem_wmask  = 4'b1111;
      end
      StDone:  done = 1'b1;
      default: ;
    endcase
  end

  assign remaining = remaining_q;

endmodule

// File: tb/tb_mem_bus_dma.sv
// Directed bench for mem_bus_dma: a bus responder with programmable read/write stalls
// logs bus traffic, and the main sequence compares it against hand-computed values.
module tb_mem_bus_dma;
  localparam int AW = 32;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] src_addr = '0;
  logic [AW-1:0] dst_addr = '0;
  logic [LW-1:0] word_count = '0;
  logic          busy, done;
  logic [LW-1:0] remaining;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_wmask;
  logic          mem_rstrb, mem_access;
  logic [31:0]   mem_rdata = '0;
  logic          mem_rbusy = 1'b0;
  logic          mem_wbusy = 1'b0;

  mem_bus_dma #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .word_count (word_count),
    .busy       (busy),
    .done       (done),
    .remaining  (remaining),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wmask  (mem_wmask),
    .mem_rstrb  (mem_rstrb),
    .mem_access (mem_access),
    .mem_rdata  (mem_rdata),
    .mem_rbusy  (mem_rbusy),
    .mem_wbusy  (mem_wbusy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  int unsigned t0 = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ram(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return {a[15:0], ~a[15:0]};
  endfunction

  logic [31:0] rd_addr_l[$];
  logic [31:0] wr_addr_l[$];
  logic [31:0] wr_data_l[$];
  logic [3:0]  wr_mask_l[$];
  int          wr_cyc_l[$];
  int          done_cyc_l[$];
  logic [15:0] rem_l[$];
  logic [15:0] done_rem_l[$];
  int          ovl_err = 0;
  int          wstab_err = 0;
  int          wr_cycles = 0;
  int          rd_stall = 0;
  int          wr_stall = 0;

  // Bus responder: decides rbusy/wbusy and rdata for the upcoming edge, and logs traffic.
  initial begin : responder
    int          rd_cnt;
    int          wr_cnt;
    bit          wr_active;
    logic [31:0] s_addr, s_data;
    logic [3:0]  s_mask;
    logic [15:0] s_rem;
    rd_cnt = 0;
    wr_cnt = 0;
    wr_active = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        wr_active = 1'b0;
        rd_cnt = 0;
        mem_rbusy = 1'b0;
        mem_wbusy = 1'b0;
        continue;
      end
      if (mem_rstrb && mem_wmask != 4'b0) ovl_err++;
      if (done) begin
        done_cyc_l.push_back(int'(cyc - t0));
        done_rem_l.push_back(remaining);
      end
      if (mem_rstrb) begin
        rd_addr_l.push_back(mem_addr);
        rem_l.push_back(remaining);
        rd_cnt = rd_stall;
        mem_rbusy = 1'b1;
      end else if (mem_access && mem_wmask == 4'b0) begin
        if (rd_cnt > 0) begin
          mem_rbusy = 1'b1;
          rd_cnt--;
        end else begin
          mem_rbusy = 1'b0;
          mem_rdata = ram(mem_addr);
        end
      end
      if (mem_wmask != 4'b0) begin
        wr_cycles++;
        if (!wr_active) begin
          wr_active = 1'b1;
          wr_cnt = wr_stall;
          s_addr = mem_addr;
          s_data = mem_wdata;
          s_mask = mem_wmask;
          s_rem = remaining;
        end else if (mem_addr !== s_addr || mem_wdata !== s_data || mem_wmask !== s_mask ||
                     remaining !== s_rem) begin
          wstab_err++;
        end
        if (wr_cnt > 0) begin
          mem_wbusy = 1'b1;
          wr_cnt--;
        end else begin
          mem_wbusy = 1'b0;
          wr_active = 1'b0;
          wr_addr_l.push_back(mem_addr);
          wr_data_l.push_back(mem_wdata);
          wr_mask_l.push_back(mem_wmask);
          wr_cyc_l.push_back(int'(cyc - t0));
        end
      end
    end
  end

  task automatic clear_logs();
    rd_addr_l.delete();
    wr_addr_l.delete();
    wr_data_l.delete();
    wr_mask_l.delete();
    wr_cyc_l.delete();
    done_cyc_l.delete();
    rem_l.delete();
    done_rem_l.delete();
    wr_cycles = 0;
    wstab_err = 0;
  endtask

  // Start is high for exactly cycle 0; returns #1 into cycle 1.
  task automatic kick(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
    @(posedge clk);
    #1;
    src_addr = s;
    dst_addr = d;
    word_count = n;
    start = 1'b1;
    t0 = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq({tag, "_done_seen"}, 64'(ok), 64'd1);
  endtask

  initial begin
    // Reset state, checked before any clock edge.
    #1;
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_remaining", 64'(remaining), 64'd0);
    check_eq("rst_bus", {mem_addr, mem_wdata}, 64'd0);
    check_eq("rst_strobes", {58'd0, mem_wmask, mem_rstrb, mem_access}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Single word, no stalls.
    clear_logs();
    kick(32'h100, 32'h200, 16'd1);
    check_eq("single_c1_busy", 64'(busy), 64'd1);
    check_eq("single_c1_rstrb_addr", {31'd0, mem_rstrb, mem_addr}, {31'd0, 1'b1, 32'h100});
    wait_done("single");
    @(negedge clk);
    check_eq("single_reads", 64'(rd_addr_l.size()), 64'd1);
    check_eq("single_writes", 64'(wr_addr_l.size()), 64'd1);
    if (wr_addr_l.size() == 1) begin
      check_eq("single_waddr", 64'(wr_addr_l[0]), 64'h200);
      check_eq("single_wdata", 64'(wr_data_l[0]), 64'hDEADBEEF);
      check_eq("single_wmask", 64'(wr_mask_l[0]), 64'hF);
      check_eq("single_wcyc", 64'(wr_cyc_l[0]), 64'd3);
    end
    if (done_cyc_l.size() > 0) check_eq("single_done_cyc", 64'(done_cyc_l[0]), 64'd4);

    // Four words, reads stalled two cycles each.
    clear_logs();
    rd_stall = 2;
    kick(32'h1000, 32'h2000, 16'd4);
    wait_done("rstall");
    @(negedge clk);
    rd_stall = 0;
    check_eq("rstall_reads", 64'(rd_addr_l.size()), 64'd4);
    check_eq("rstall_writes", 64'(wr_addr_l.size()), 64'd4);
    for (int i = 0; i < 4 && i < rd_addr_l.size() && i < wr_addr_l.size(); i++) begin
      check_eq($sformatf("rstall_raddr%0d", i), 64'(rd_addr_l[i]), 64'(32'h1000 + 4 * i));
      check_eq($sformatf("rstall_waddr%0d", i), 64'(wr_addr_l[i]), 64'(32'h2000 + 4 * i));
      check_eq($sformatf("rstall_wdata%0d", i), 64'(wr_data_l[i]), 64'(ram(32'h1000 + 4 * i)));
      check_eq($sformatf("rstall_rem%0d", i), 64'(rem_l[i]), 64'(4 - i));
    end
    if (done_cyc_l.size() > 0) begin
      check_eq("rstall_done_cyc", 64'(done_cyc_l[0]), 64'd21);
      check_eq("rstall_done_rem", 64'(done_rem_l[0]), 64'd0);
    end

    // One word, write stalled three cycles.
    clear_logs();
    wr_stall = 3;
    kick(32'h300, 32'h400, 16'd1);
    wait_done("wstall");
    @(negedge clk);
    wr_stall = 0;
    check_eq("wstall_stable", 64'(wstab_err), 64'd0);
    check_eq("wstall_wcycles", 64'(wr_cycles), 64'd4);
    check_eq("wstall_writes", 64'(wr_addr_l.size()), 64'd1);
    if (wr_data_l.size() == 1) check_eq("wstall_wdata", 64'(wr_data_l[0]), 64'(ram(32'h300)));
    if (done_cyc_l.size() > 0) begin
      check_eq("wstall_done_cyc", 64'(done_cyc_l[0]), 64'd7);
      check_eq("wstall_done_rem", 64'(done_rem_l[0]), 64'd0);
    end

    // Zero count finishes with no bus traffic.
    clear_logs();
    kick(32'h100, 32'h200, 16'd0);
    wait_done("zero");
    @(negedge clk);
    check_eq("zero_reads", 64'(rd_addr_l.size()), 64'd0);
    check_eq("zero_writes", 64'(wr_cycles), 64'd0);
    if (done_cyc_l.size() > 0) check_eq("zero_done_cyc", 64'(done_cyc_l[0]), 64'd1);

    // Start while busy and while in DONE is ignored.
    clear_logs();
    kick(32'hA00, 32'hB00, 16'd2);
    @(posedge clk);
    #1;
    src_addr = 32'hC00;
    dst_addr = 32'hD00;
    word_count = 16'd5;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("busystart");
    word_count = 16'd3;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check_eq("busystart_after_done_idle", 64'(busy), 64'd0);
    check_eq("busystart_writes", 64'(wr_addr_l.size()), 64'd2);
    if (wr_addr_l.size() == 2) begin
      check_eq("busystart_waddr0", 64'(wr_addr_l[0]), 64'hB00);
      check_eq("busystart_waddr1", 64'(wr_addr_l[1]), 64'hB04);
    end
    if (done_cyc_l.size() > 0) check_eq("busystart_done_cyc", 64'(done_cyc_l[0]), 64'd7);

    // Unaligned source wrapping past the top of the address space.
    clear_logs();
    kick(32'hFFFF_FFFE, 32'h501, 16'd2);
    wait_done("wrap");
    @(negedge clk);
    check_eq("wrap_reads", 64'(rd_addr_l.size()), 64'd2);
    if (rd_addr_l.size() == 2) begin
      check_eq("wrap_raddr0", 64'(rd_addr_l[0]), 64'hFFFF_FFFC);
      check_eq("wrap_raddr1", 64'(rd_addr_l[1]), 64'h0);
    end
    if (wr_addr_l.size() == 2) begin
      check_eq("wrap_waddr0", 64'(wr_addr_l[0]), 64'h500);
      check_eq("wrap_waddr1", 64'(wr_addr_l[1]), 64'h504);
      check_eq("wrap_wdata1", 64'(wr_data_l[1]), 64'(ram(32'h0)));
    end

    // Reset during the read wait of word 2 of 4.
    clear_logs();
    rd_stall = 2;
    kick(32'h800, 32'h900, 16'd4);
    for (int i = 0; i < 100 && rd_addr_l.size() < 2; i++) @(negedge clk);
    check_eq("rstmid_reached_word2", 64'(rd_addr_l.size()), 64'd2);
    @(posedge clk);
    #1;
    check_eq("rstmid_in_readwait", {62'd0, busy, mem_access}, 64'd3);
    reset = 1'b1;
    #1;
    check_eq("rstmid_busy", 64'(busy), 64'd0);
    check_eq("rstmid_remaining", 64'(remaining), 64'd0);
    check_eq("rstmid_bus", {mem_addr, mem_wdata}, 64'd0);
    check_eq("rstmid_strobes", {58'd0, mem_wmask, mem_rstrb, mem_access}, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    rd_stall = 0;
    repeat (2) @(negedge clk);
    check_eq("rstmid_no_done", 64'(done_cyc_l.size()), 64'd0);
    clear_logs();
    kick(32'h100, 32'h600, 16'd1);
    wait_done("rstmid_restart");
    @(negedge clk);
    check_eq("rstmid_restart_writes", 64'(wr_addr_l.size()), 64'd1);
    if (wr_addr_l.size() == 1) begin
      check_eq("rstmid_restart_waddr", 64'(wr_addr_l[0]), 64'h600);
      check_eq("rstmid_restart_wdata", 64'(wr_data_l[0]), 64'hDEADBEEF);
    end
    if (done_cyc_l.size() > 0) check_eq("rstmid_restart_done_cyc", 64'(done_cyc_l[0]), 64'd4);

    check_eq("no_rstrb_wmask_overlap", 64'(ovl_err), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
